// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus-based CPU datapath.
package cpu_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    // Value a bus driver presents when it is not enabled.
    localparam data_t BUS_IDLE = 'z;

endpackage : cpu_pkg

// File: rtl/tristate_buf.sv
// Generic tri-state bus driver used by every register that talks to the shared
// bus (A, B, PC, MAR, OUT). Purely combinational: no register stage.
module tristate_buf #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic             oe,
    output logic [WIDTH-1:0] out
);

    // Drive the input when enabled, otherwise release every bit to high-Z.
    assign out = oe ? in : {WIDTH{1'bz}};

endmodule : tristate_buf

// File: rtl/accumulator_reg.sv
// Accumulator (A register) of the CPU datapath. Captures the shared bus on a
// load strobe, drives its value back to the bus through a tri-state buffer and
// presents it continuously, with zero and sign flags, to the ALU.
module accumulator_reg
    import cpu_pkg::*;
#(
    parameter int               WIDTH   = DATA_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus,
    input  logic             load,
    input  logic             enable_output,
    output logic [WIDTH-1:0] regA,
    output logic [WIDTH-1:0] a_alu,
    output logic             a_zero,
    output logic             a_neg
);

    logic [WIDTH-1:0] a_q;

    // A register: asynchronous reset to RST_VAL, capture bus when load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= RST_VAL;
        end else if (load) begin
            // NOTE: non-blocking so every register in the datapath samples the
            // bus value from before this edge, whatever the evaluation order.
            a_q <= bus;
        end
    end

    // ALU operand and flags depend on A alone, never on the output enable.
    always_comb begin
        a_alu  = a_q;
        a_zero = (a_q == '0);
        a_neg  = a_q[WIDTH-1];
    end

    // Bus-side driver; contention avoidance is left to the controller.
    tristate_buf #(
        .WIDTH (WIDTH)
    ) u_reg_a_buf (
        .in  (a_q),
        .oe  (enable_output),
        .out (regA)
    );

endmodule : accumulator_reg

// File: tb/tb_accumulator_reg.sv
// Directed bench for accumulator_reg. Expected register contents are queued
// when a load/hold step is driven and popped once the clock edge has happened.
// The regA net carries a pull-up, so a released (high-Z) driver reads as all ones.
module tb_accumulator_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus;
    logic       load;
    logic       enable_output;
    wire  [7:0] reg_a_net;
    logic [7:0] a_alu;
    logic       a_zero;
    logic       a_neg;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_a;

    localparam logic [7:0] IDLE_READ = 8'hFF;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (reg_a_net[i]);
    end

    accumulator_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .load          (load),
        .enable_output (enable_output),
        .regA          (reg_a_net),
        .a_alu         (a_alu),
        .a_zero        (a_zero),
        .a_neg         (a_neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all ALU-side outputs against one expected A value.
    task automatic check_a(input string tag, input logic [7:0] exp);
        check({tag, "_alu"}, a_alu, exp);
        check({tag, "_zero"}, {7'd0, a_zero}, {7'd0, exp == 8'h00});
        check({tag, "_neg"}, {7'd0, a_neg}, {7'd0, exp[7]});
    endtask

    // Drive one clocked step, queue the expected A, check after the edge.
    task automatic step(input string tag, input logic ld, input logic [7:0] value);
        bus  = value;
        load = ld;
        if (ld) sb.push_back(value);
        else    sb.push_back(exp_a);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            exp_a = sb.pop_front();
            check_a(tag, exp_a);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        load          = 1'b1;
        bus           = 8'hAA;
        enable_output = 1'b0;
        exp_a         = 8'h00;

        // 1. Reset with load asserted and clock running.
        repeat (3) @(posedge clk);
        #1;
        check_a("rst", 8'h00);
        check("rst_regA_off", reg_a_net, IDLE_READ);
        enable_output = 1'b1;
        #1;
        check("rst_regA_on", reg_a_net, 8'h00);
        enable_output = 1'b0;
        load          = 1'b0;
        rst_n         = 1'b1;

        // 2. Load then hold with a changing bus.
        step("load5c", 1'b1, 8'h5C);
        step("hold1", 1'b0, 8'h11);
        step("hold2", 1'b0, 8'h11);
        step("hold3", 1'b0, 8'h11);

        // 3. Output enable toggling leaves A untouched.
        enable_output = 1'b1;
        #1;
        check("oe_on", reg_a_net, 8'h5C);
        enable_output = 1'b0;
        #1;
        check("oe_off", reg_a_net, IDLE_READ);
        check("oe_off_alu", a_alu, 8'h5C);

        // 4. Simultaneous load and output enable.
        step("load01", 1'b1, 8'h01);
        enable_output = 1'b1;
        bus           = 8'h80;
        load          = 1'b1;
        #1;
        check("simul_before", reg_a_net, 8'h01);
        step("simul", 1'b1, 8'h80);
        check("simul_after", reg_a_net, 8'h80);
        enable_output = 1'b0;

        // 5. Asynchronous reset between edges.
        step("loadff", 1'b1, 8'hFF);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 8'h00);
        exp_a = 8'h00;
        #1;
        rst_n = 1'b1;
        step("load00", 1'b1, 8'h00);

        // 6. Sweep every value, one per edge, with the driver enabled.
        enable_output = 1'b1;
        for (int v = 0; v < 256; v++) begin
            step("sweep", 1'b1, 8'(v));
            check("sweep_regA", reg_a_net, exp_a);
        end
        enable_output = 1'b0;
        load          = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_accumulator_reg
